// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset/lock sequencer producing the core system reset and ready.
// Ports:
//   inclk0      reference clock, the only clock
//   areset      asynchronous active-high reset
//   pll_locked  PLL lock, asynchronous to inclk0
//   force_reset synchronous soft-reset request (level or pulse)
//   pll_rst     reset to the PLL
//   sys_reset   core reset, asserts async with areset, deasserts on inclk0
//   ready       high only while running
//   retry_cnt   saturating count of timeout / lock-loss retries
module pll_reset_ctrl #(
  parameter int RST_PULSE    = 8,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 50000
) (
  input  logic       inclk0,
  input  logic       areset,
  input  logic       pll_locked,
  input  logic       force_reset,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] retry_cnt
);
  localparam int M1 = RST_PULSE > LOCK_FILTER ? RST_PULSE : LOCK_FILTER;
  localparam int MAXV = M1 > LOCK_TIMEOUT ? M1 : LOCK_TIMEOUT;
  localparam int CW = $clog2(MAXV) + 1;
  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, FILTER, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] retry_q, retry_d;
  logic sync_q, locked_s_q;
  logic pll_rst_q, sys_reset_q, ready_q;
  logic bump;
  // One shared counter serves the reset pulse, the timeout and the lock filter;
  // every state change clears it so each phase counts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    bump = 1'b0;
    if (force_reset) begin
      state_d = PLL_RST;
      cnt_d = '0;
    end else begin
      case (state_q)
        PLL_RST: if (cnt_q == CW'(RST_PULSE - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d = '0;
        end
        // Lock is tested before expiry so a lock arriving on the timeout edge wins.
        WAIT_LOCK: if (locked_s_q) begin
          state_d = FILTER;
          cnt_d = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = PLL_RST;
          cnt_d = '0;
          bump = 1'b1;
        end
        // Loss of lock is tested before completion so a drop on the final sample aborts.
        FILTER: if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d = '0;
        end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
          state_d = RUN;
          cnt_d = '0;
        end
        RUN: begin
          cnt_d = '0;
          if (!locked_s_q) begin
            state_d = PLL_RST;
            bump = 1'b1;
          end
        end
        default: begin
          state_d = PLL_RST;
          cnt_d = '0;
        end
      endcase
    end
  end
  assign retry_d = (bump && retry_q != 8'hff) ? retry_q + 8'd1 : retry_q;
  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge inclk0 or posedge areset) begin
    if (areset) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      sync_q      <= 1'b0;
      locked_s_q  <= 1'b0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= pll_locked;
      locked_s_q  <= sync_q;
      retry_q     <= retry_d;
      pll_rst_q   <= state_d == PLL_RST;
      sys_reset_q <= state_d != RUN;
      ready_q     <= state_d == RUN;
    end
  end
  assign pll_rst = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign ready = ready_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: scoreboard bench; stimulus queues expected output changes, a monitor checks them.
module tb_pll_reset_ctrl;
  logic clk = 1'b0;
  logic areset, pll_locked, force_reset;
  logic pll_rst, sys_reset, ready;
  logic [7:0] retry_cnt;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct packed {
    int c;
    logic [10:0] v;
  } ev_t;
  ev_t q[$];
  ev_t e;
  logic [10:0] prev, cur;
  bit first = 1'b1;

  pll_reset_ctrl #(.RST_PULSE(4), .LOCK_FILTER(8), .LOCK_TIMEOUT(32)) dut (
    .inclk0(clk),
    .areset(areset),
    .pll_locked(pll_locked),
    .force_reset(force_reset),
    .pll_rst(pll_rst),
    .sys_reset(sys_reset),
    .ready(ready),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every output change is one event; it must match the oldest queued expectation in cycle and value.
  always @(negedge clk) begin
    cur = {pll_rst, sys_reset, ready, retry_cnt};
    if (first || cur !== prev) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.v !== cur) begin
          n_fail++;
          $display("FAIL event got cyc=%0d val=%b required cyc=%0d val=%b", cyc, cur, e.c, e.v);
        end
      end
    end
    prev = cur;
    first = 1'b0;
  end

  function automatic logic [7:0] sat(input int x);
    return x > 255 ? 8'd255 : 8'(x);
  endfunction

  task automatic push_ev(input int c, input logic pr, input logic sr, input logic rd, input logic [7:0] rc);
    ev_t t;
    t.c = c;
    t.v = {pr, sr, rd, rc};
    q.push_back(t);
  endtask

  task automatic at(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int n, a, b, c, d, f, g, h;
    logic [10:0] rv;
    areset = 1'b1;
    pll_locked = 1'b0;
    force_reset = 1'b0;
    push_ev(1, 1, 1, 0, 0);
    // nominal lock
    n = 3;
    at(n);
    areset = 1'b0;
    push_ev(n + 4, 0, 1, 0, 0);
    at(n + 6);
    pll_locked = 1'b1;
    push_ev(n + 17, 0, 0, 1, 0);
    // lock loss in run, then re-lock
    a = n + 20;
    at(a);
    pll_locked = 1'b0;
    push_ev(a + 3, 1, 1, 0, 1);
    push_ev(a + 7, 0, 1, 0, 1);
    at(a + 8);
    pll_locked = 1'b1;
    push_ev(a + 19, 0, 0, 1, 1);
    // one-cycle force_reset in run
    b = a + 22;
    at(b);
    force_reset = 1'b1;
    push_ev(b + 1, 1, 1, 0, 1);
    push_ev(b + 5, 0, 1, 0, 1);
    push_ev(b + 14, 0, 0, 1, 1);
    at(b + 1);
    force_reset = 1'b0;
    // force_reset held 20 cycles, then a lock glitch during filtering
    c = b + 17;
    at(c);
    force_reset = 1'b1;
    push_ev(c + 1, 1, 1, 0, 1);
    push_ev(c + 24, 0, 1, 0, 1);
    at(c + 2);
    pll_locked = 1'b0;
    at(c + 20);
    force_reset = 1'b0;
    at(c + 26);
    pll_locked = 1'b1;
    at(c + 31);
    pll_locked = 1'b0;
    at(c + 32);
    pll_locked = 1'b1;
    push_ev(c + 43, 0, 0, 1, 1);
    // timeouts, then lock arriving on the timeout edge
    d = c + 46;
    at(d);
    pll_locked = 1'b0;
    push_ev(d + 3, 1, 1, 0, 2);
    push_ev(d + 7, 0, 1, 0, 2);
    push_ev(d + 39, 1, 1, 0, 3);
    push_ev(d + 43, 0, 1, 0, 3);
    push_ev(d + 75, 1, 1, 0, 4);
    push_ev(d + 79, 0, 1, 0, 4);
    at(d + 108);
    pll_locked = 1'b1;
    push_ev(d + 119, 0, 0, 1, 4);
    // lock lost on the edge the filter would complete
    h = d + 122;
    at(h);
    force_reset = 1'b1;
    push_ev(h + 1, 1, 1, 0, 4);
    push_ev(h + 5, 0, 1, 0, 4);
    at(h + 1);
    force_reset = 1'b0;
    at(h + 11);
    pll_locked = 1'b0;
    at(h + 12);
    pll_locked = 1'b1;
    push_ev(h + 23, 0, 0, 1, 4);
    // async reset mid-filter
    f = h + 26;
    at(f);
    force_reset = 1'b1;
    push_ev(f + 1, 1, 1, 0, 4);
    push_ev(f + 5, 0, 1, 0, 4);
    at(f + 1);
    force_reset = 1'b0;
    at(f + 8);
    #2;
    areset = 1'b1;
    push_ev(f + 9, 1, 1, 0, 0);
    #1;
    rv = {pll_rst, sys_reset, ready, retry_cnt};
    n_chk++;
    if (rv !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL async_reset got=%b required=%b", rv, {1'b1, 1'b1, 1'b0, 8'd0});
    end
    at(f + 10);
    #2;
    areset = 1'b0;
    push_ev(f + 14, 0, 1, 0, 0);
    push_ev(f + 23, 0, 0, 1, 0);
    // lock loss then 260 timeouts: retry_cnt saturates
    g = f + 26;
    at(g);
    pll_locked = 1'b0;
    for (int j = 0; j <= 260; j++) begin
      push_ev(g + 3 + 36 * j, 1, 1, 0, sat(1 + j));
      push_ev(g + 7 + 36 * j, 0, 1, 0, sat(1 + j));
    end
    at(g + 7 + 36 * 260 + 3);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events got=%0d required=0 next_cyc=%0d", q.size(), q[0].c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
